z80_int_ctrl: RTL and testbench

Prioritised, nested interrupt controller for the Z80 mini board, sharing the single open-drain `nINT` line between the PS/2 receiver, the 8251 console (`CONIRQ`) and future sources. It sits in the glue FPGA beside the bank mapper and replaces the fixed IM2 vector with a per-source vector. Sources are edge-latched into a pending register, gated by a mask, and arbitrated against the in-service set. The CPU programs and clears it through four I/O registers.

---
 rtl/z80_int_pkg.sv | 29 ++
 rtl/z80_int_ctrl_sync.sv | 27 ++
 rtl/z80_int_ctrl.sv | 127 ++++++++++++
 tb/tb_z80_int_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/z80_int_pkg.sv
// Shared constants and helpers for the Z80 prioritised interrupt controller.
package z80_int_pkg;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_ISR  = 2'd2;
    localparam logic [1:0] REG_LAST = 2'd3;

    localparam int SYNC_DEPTH = 2;

    // Lowest set bit index of v, or none_idx when v is empty; bit 0 wins.
    function automatic logic [3:0] lowest_idx(input logic [7:0] v, input logic [3:0] none_idx);
        logic [3:0] idx;
        idx = none_idx;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [7:0] spurious_vec(input logic [7:0] base, input logic [3:0] n_src);
        return base + {3'b000, n_src, 1'b0};
    endfunction

endpackage

// File: rtl/z80_int_ctrl_sync.sv
// Per-source 2-flop synchroniser with a single-cycle rising-edge pulse.
module irq_edge_sync
    import z80_int_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic irq_i,
    output logic rise_o
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;

    // Synchroniser chain plus edge history.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], irq_i};
            prev_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign rise_o = sync_q[SYNC_DEPTH-1] & ~prev_q;

endmodule

// File: rtl/z80_int_ctrl.sv
// Prioritised, nested IM2 interrupt controller with per-source vectors.
module z80_int_ctrl
    import z80_int_pkg::*;
#(
    parameter int         N_SRC    = 4,
    parameter logic [7:0] VEC_BASE = 8'h00
) (
    input  logic             CLK50MHz,
    input  logic             nRESET,
    input  logic             CPUCLK0,
    input  logic             cs,
    input  logic [1:0]       A,
    input  logic [7:0]       D_in,
    input  logic             nIORQ,
    input  logic             nM1,
    input  logic             nRD,
    input  logic             nWR,
    input  logic [N_SRC-1:0] irq_src,
    output logic             int_out,
    output logic             vec_oe,
    output logic [7:0]       vec,
    output logic             rd_oe,
    output logic [7:0]       rd_data
);

    logic [N_SRC-1:0] mask_q, mask_d, pend_q, pend_d, isr_q, isr_d;
    logic [7:0]       last_q, last_d, vec_q, vec_d;
    logic             int_q, int_d, ack_q;
    logic [N_SRC-1:0] rise_s, pend_clr_s, isr_clr_s, isr_set_s, win_oh_s;
    logic [7:0]       cand_s;
    logic [3:0]       w_s, h_s;
    logic             ack_s, ack_rise_s, wr_en_s, win_valid_s;

    for (genvar i = 0; i < N_SRC; i++) begin : g_sync
        irq_edge_sync u_sync (
            .clk_i   (CLK50MHz),
            .rst_n_i (nRESET),
            .irq_i   (irq_src[i]),
            .rise_o  (rise_s[i])
        );
    end

    assign ack_s       = !nM1 && !nIORQ;
    assign ack_rise_s  = ack_s && !ack_q;
    assign wr_en_s     = CPUCLK0 && cs && !nIORQ && !nWR;
    assign cand_s      = 8'(pend_q & mask_q);
    assign w_s         = lowest_idx(cand_s, 4'(N_SRC));
    assign h_s         = lowest_idx(8'(isr_q), 4'(N_SRC));
    assign win_valid_s = (cand_s != 8'h00);
    assign win_oh_s    = N_SRC'(1'b1) << w_s;

    // Next-state: register writes, acknowledge bookkeeping, edge capture.
    always_comb begin
        mask_d     = mask_q;
        last_d     = last_q;
        vec_d      = vec_q;
        pend_clr_s = '0;
        isr_clr_s  = '0;
        isr_set_s  = '0;
        if (wr_en_s) begin
            case (A)
                REG_MASK: mask_d     = N_SRC'(D_in);
                REG_PEND: pend_clr_s = N_SRC'(D_in);
                REG_ISR:  isr_clr_s  = N_SRC'(D_in);
                default:  mask_d     = mask_q;
            endcase
        end else begin
            mask_d = mask_q;
        end
        if (ack_rise_s) begin
            if (win_valid_s) begin
                vec_d      = VEC_BASE + {3'b000, w_s, 1'b0};
                pend_clr_s = pend_clr_s | win_oh_s;
                isr_set_s  = win_oh_s;
                last_d     = {1'b1, 4'b0000, w_s[2:0]};
            end else begin
                vec_d  = spurious_vec(VEC_BASE, 4'(N_SRC));
                last_d = 8'h00;
            end
        end else begin
            vec_d = vec_q;
        end
        // A new edge outranks any clear landing in the same cycle.
        pend_d = (pend_q & ~pend_clr_s) | rise_s;
        isr_d  = (isr_q & ~isr_clr_s) | isr_set_s;
        int_d  = win_valid_s && (w_s < h_s);
    end

    // Controller state registers.
    always_ff @(posedge CLK50MHz or negedge nRESET) begin
        if (!nRESET) begin
            mask_q <= '0;
            pend_q <= '0;
            isr_q  <= '0;
            last_q <= 8'h00;
            vec_q  <= spurious_vec(VEC_BASE, 4'(N_SRC));
            int_q  <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            pend_q <= pend_d;
            isr_q  <= isr_d;
            last_q <= last_d;
            vec_q  <= vec_d;
            int_q  <= int_d;
            ack_q  <= ack_s;
        end
    end

    // Combinational register read mux.
    always_comb begin
        rd_data = 8'h00;
        case (A)
            REG_MASK: rd_data = 8'(mask_q);
            REG_PEND: rd_data = 8'(pend_q);
            REG_ISR:  rd_data = 8'(isr_q);
            REG_LAST: rd_data = last_q;
            default:  rd_data = 8'h00;
        endcase
    end

    assign int_out = int_q;
    assign vec     = vec_q;
    assign vec_oe  = ack_s;
    assign rd_oe   = cs && !nIORQ && !nRD && nM1;

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Directed bench for z80_int_ctrl: decode table plus multi-cycle scenarios.
module tb_z80_int_ctrl;

    logic       CLK50MHz = 1'b0;
    logic       nRESET;
    logic       CPUCLK0, cs, nIORQ, nM1, nRD, nWR;
    logic [1:0] A;
    logic [7:0] D_in;
    logic [3:0] irq_src;
    logic       int_out, vec_oe, rd_oe;
    logic [7:0] vec, rd_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic cs, niorq, nm1, nrd, nwr;
        logic exp_rd_oe, exp_vec_oe;
    } dec_vec_t;

    dec_vec_t tbl[7];

    z80_int_ctrl #(.N_SRC(4), .VEC_BASE(8'h00)) dut (
        .CLK50MHz (CLK50MHz),
        .nRESET   (nRESET),
        .CPUCLK0  (CPUCLK0),
        .cs       (cs),
        .A        (A),
        .D_in     (D_in),
        .nIORQ    (nIORQ),
        .nM1      (nM1),
        .nRD      (nRD),
        .nWR      (nWR),
        .irq_src  (irq_src),
        .int_out  (int_out),
        .vec_oe   (vec_oe),
        .vec      (vec),
        .rd_oe    (rd_oe),
        .rd_data  (rd_data)
    );

    always #10 CLK50MHz = ~CLK50MHz;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        cs = 1'b0; nIORQ = 1'b1; nM1 = 1'b1; nRD = 1'b1; nWR = 1'b1;
        CPUCLK0 = 1'b0; A = 2'd0; D_in = 8'h00;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK50MHz);
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; A = a; D_in = d; nIORQ = 1'b0; nWR = 1'b0; CPUCLK0 = 1'b1;
        @(negedge CLK50MHz);
        bus_idle();
    endtask

    task automatic read_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
        cs = 1'b1; A = a; nIORQ = 1'b0; nRD = 1'b0;
        #1;
        chk(name, rd_data, exp);
        bus_idle();
    endtask

    task automatic do_ack(output logic [7:0] v);
        nM1 = 1'b0; nIORQ = 1'b0;
        @(negedge CLK50MHz);
        @(negedge CLK50MHz);
        v = vec;
        bus_idle();
    endtask

    initial begin
        logic [7:0] v;
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        nRESET = 1'b0;
        irq_src = 4'h0;
        bus_idle();
        cyc(3);
        chk("reset_int_out", int_out, 8'h00);
        chk("reset_vec", vec, 8'h08);
        nRESET = 1'b1;
        cyc(1);

        // Bus decode table, applied within one low clock phase.
        for (int i = 0; i < 7; i++) begin
            cs = tbl[i].cs; nIORQ = tbl[i].niorq; nM1 = tbl[i].nm1;
            nRD = tbl[i].nrd; nWR = tbl[i].nwr;
            #1;
            chk($sformatf("dec%0d_rd_oe", i), rd_oe, tbl[i].exp_rd_oe);
            chk($sformatf("dec%0d_vec_oe", i), vec_oe, tbl[i].exp_vec_oe);
        end
        bus_idle();
        cyc(1);
        read_chk("reset_mask", 2'd0, 8'h00);
        read_chk("reset_last", 2'd3, 8'h00);

        // Single source: capture latency, acknowledge, held level.
        cyc(1);
        write_reg(2'd0, 8'h0F);
        irq_src = 4'h4;
        cyc(2);
        read_chk("s1_pend_e2", 2'd1, 8'h00);
        cyc(1);
        read_chk("s1_pend_e3", 2'd1, 8'h04);
        chk("s1_int_e3", int_out, 8'h00);
        cyc(1);
        chk("s1_int_e4", int_out, 8'h01);
        do_ack(v);
        chk("s1_vec", v, 8'h04);
        chk("s1_int_after", int_out, 8'h00);
        cyc(2);
        read_chk("s1_pend", 2'd1, 8'h00);
        read_chk("s1_isr", 2'd2, 8'h04);
        read_chk("s1_last", 2'd3, 8'h82);
        irq_src = 4'h0;
        cyc(3);

        // Nesting: source 1 preempts ISR=2, source 3 waits for full EOI.
        irq_src = 4'hA;
        cyc(4);
        chk("s2_int", int_out, 8'h01);
        irq_src = 4'h0;
        do_ack(v);
        chk("s2_vec1", v, 8'h02);
        read_chk("s2_isr", 2'd2, 8'h06);
        read_chk("s2_pend", 2'd1, 8'h08);
        chk("s2_int_blk", int_out, 8'h00);
        cyc(1);
        write_reg(2'd2, 8'h02);
        cyc(2);
        chk("s2_int_eoi1", int_out, 8'h00);
        read_chk("s2_isr_eoi1", 2'd2, 8'h04);
        cyc(1);
        write_reg(2'd2, 8'h04);
        chk("s2_int_eoi2_e0", int_out, 8'h00);
        cyc(1);
        chk("s2_int_eoi2_e1", int_out, 8'h01);
        do_ack(v);
        chk("s2_vec3", v, 8'h06);
        cyc(1);
        write_reg(2'd2, 8'h01);
        read_chk("s2_eoi_zero", 2'd2, 8'h08);
        cyc(1);
        write_reg(2'd2, 8'h08);
        read_chk("s2_isr_clear", 2'd2, 8'h00);

        // Masked capture then unmask.
        cyc(1);
        write_reg(2'd0, 8'h00);
        irq_src = 4'h1;
        cyc(4);
        irq_src = 4'h0;
        read_chk("s3_pend", 2'd1, 8'h01);
        chk("s3_int_masked", int_out, 8'h00);
        cyc(1);
        write_reg(2'd0, 8'h01);
        chk("s3_int_e0", int_out, 8'h00);
        read_chk("s3_pend_kept", 2'd1, 8'h01);
        cyc(1);
        chk("s3_int_e1", int_out, 8'h01);
        do_ack(v);
        chk("s3_vec", v, 8'h00);

        // Spurious acknowledge.
        cyc(1);
        do_ack(v);
        chk("s4_vec", v, 8'h08);
        read_chk("s4_last", 2'd3, 8'h00);
        read_chk("s4_isr", 2'd2, 8'h01);
        read_chk("s4_pend", 2'd1, 8'h00);
        cyc(1);
        write_reg(2'd2, 8'h01);

        // Write-1-clear alone, then coincident with a fresh edge.
        irq_src = 4'h2;
        cyc(4);
        irq_src = 4'h0;
        read_chk("s5_pend_set", 2'd1, 8'h02);
        cyc(1);
        write_reg(2'd1, 8'h02);
        read_chk("s5_pend_clr", 2'd1, 8'h00);
        cyc(4);
        irq_src = 4'h2;
        cyc(2);
        write_reg(2'd1, 8'h02);
        read_chk("s5_pend_race", 2'd1, 8'h02);
        irq_src = 4'h0;

        // Reset in the middle of an acknowledge.
        cyc(1);
        write_reg(2'd0, 8'h02);
        cyc(1);
        chk("s6_int_pre", int_out, 8'h01);
        nM1 = 1'b0; nIORQ = 1'b0;
        cyc(1);
        chk("s6_vec_pre", vec, 8'h02);
        nRESET = 1'b0;
        #1;
        chk("s6_int_rst", int_out, 8'h00);
        chk("s6_vec_rst", vec, 8'h08);
        chk("s6_vec_oe_rst", vec_oe, 8'h01);
        bus_idle();
        read_chk("s6_mask", 2'd0, 8'h00);
        read_chk("s6_pend", 2'd1, 8'h00);
        read_chk("s6_isr", 2'd2, 8'h00);
        read_chk("s6_last", 2'd3, 8'h00);
        cyc(1);
        nRESET = 1'b1;
        cyc(2);
        chk("s6_int_post", int_out, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
